// File: rtl/angle_frame_parser_if.sv
// Byte-stream input and decoded-angle output bundle for angle_frame_parser.
interface angle_frame_parser_if #(
    parameter int unsigned NCH   = 3,
    parameter int unsigned OUT_W = 16
);
    logic [7:0]           rx_data;
    logic                 rx_done;
    logic [NCH*OUT_W-1:0] angle_out;
    logic                 ang_valid;
    logic                 sum_err;
    logic                 tmo_err;
    logic [7:0]           err_cnt;

    // Byte source side (UART receiver / bench)
    modport master (
        output rx_data, rx_done,
        input  angle_out, ang_valid, sum_err, tmo_err, err_cnt
    );

    // Parser side
    modport slave (
        input  rx_data, rx_done,
        output angle_out, ang_valid, sum_err, tmo_err, err_cnt
    );
endinterface

// File: rtl/angle_frame_parser.sv
// Header-hunting frame parser: checksums a fixed-length frame of little-endian
// signed 16-bit words and publishes NCH scaled channels.
module angle_frame_parser #(
    parameter logic [7:0]  HDR0        = 8'h55,
    parameter logic [7:0]  HDR1        = 8'h53,
    parameter int unsigned FRAME_LEN   = 11,
    parameter int unsigned NCH         = 3,
    parameter int unsigned OUT_W       = 16,
    parameter int unsigned SCALE_MUL   = 41,
    parameter int unsigned SCALE_SHIFT = 12,
    parameter int unsigned DECIM       = 1,
    parameter int unsigned TIMEOUT_CYC = 5000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    angle_frame_parser_if.slave  bus
);
    localparam int unsigned NB      = 2 * NCH;
    localparam int unsigned PAY_LEN = FRAME_LEN - 3;
    localparam int unsigned IDX_W   = $clog2(PAY_LEN + 1);
    localparam int unsigned TMO_W   = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned DEC_W   = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int unsigned PROD_W  = 17 + 32;

    typedef enum logic [2:0] {HUNT, TYPE, PAYLOAD, CHECK, SCALE} state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [7:0]         sum;
    logic [DEC_W-1:0]   dec_cnt;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [7:0]         pay [NB];

    logic [15:0]          raw_c [NCH];
    logic [16:0]          mag_c [NCH];
    logic [PROD_W-1:0]    q_c   [NCH];
    logic [NCH*OUT_W-1:0] scaled_c;
    logic                 tmo_fire_c;

    // Sign-magnitude scaling of every captured channel word (truncates toward zero)
    always_comb begin
        scaled_c = '0;
        for (int k = 0; k < NCH; k++) begin
            raw_c[k] = {pay[2*k+1], pay[2*k]};
            // 17-bit magnitude so that -32768 maps to +32768
            mag_c[k] = raw_c[k][15] ? (17'd0 - {raw_c[k][15], raw_c[k]})
                                    : {1'b0, raw_c[k]};
            q_c[k]   = (PROD_W'(mag_c[k]) * PROD_W'(SCALE_MUL)) >> SCALE_SHIFT;
            scaled_c[k*OUT_W +: OUT_W] = raw_c[k][15] ? OUT_W'(PROD_W'(0) - q_c[k])
                                                      : OUT_W'(q_c[k]);
        end
    end

    // Idle-timeout expiry; an arriving byte in the same cycle takes precedence
    always_comb begin
        tmo_fire_c = (state inside {TYPE, PAYLOAD, CHECK}) && !bus.rx_done &&
                     (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
    end

    // Frame FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= HUNT;
            idx           <= '0;
            sum           <= '0;
            dec_cnt       <= '0;
            tmo_cnt       <= '0;
            for (int k = 0; k < NB; k++) pay[k] <= '0;
            bus.angle_out <= '0;
            bus.ang_valid <= 1'b0;
            bus.sum_err   <= 1'b0;
            bus.tmo_err   <= 1'b0;
            bus.err_cnt   <= '0;
        end else begin
            bus.ang_valid <= 1'b0;
            bus.sum_err   <= 1'b0;
            bus.tmo_err   <= 1'b0;

            // Idle counter only runs while a frame is in progress
            if (!(state inside {TYPE, PAYLOAD, CHECK}) || bus.rx_done) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end

            if (tmo_fire_c) begin
                state       <= HUNT;
                bus.tmo_err <= 1'b1;
                bus.err_cnt <= (bus.err_cnt == 8'hFF) ? 8'hFF : bus.err_cnt + 8'd1;
            end else begin
                case (state)
                    HUNT: begin
                        if (bus.rx_done && bus.rx_data == HDR0) begin
                            state <= TYPE;
                            sum   <= HDR0;
                        end
                    end
                    TYPE: begin
                        if (bus.rx_done) begin
                            if (bus.rx_data == HDR1) begin
                                state <= PAYLOAD;
                                sum   <= sum + bus.rx_data;
                                idx   <= '0;
                            end else if (bus.rx_data == HDR0) begin
                                sum <= HDR0;
                            end else begin
                                state <= HUNT;
                            end
                        end
                    end
                    PAYLOAD: begin
                        if (bus.rx_done) begin
                            for (int k = 0; k < NB; k++) begin
                                if (idx == IDX_W'(k)) pay[k] <= bus.rx_data;
                            end
                            sum <= sum + bus.rx_data;
                            if (idx == IDX_W'(PAY_LEN - 1)) begin
                                state <= CHECK;
                                idx   <= '0;
                            end else begin
                                idx <= idx + IDX_W'(1);
                            end
                        end
                    end
                    CHECK: begin
                        if (bus.rx_done) begin
                            if (bus.rx_data == sum) begin
                                state <= SCALE;
                            end else begin
                                state       <= HUNT;
                                bus.sum_err <= 1'b1;
                                bus.err_cnt <= (bus.err_cnt == 8'hFF) ? 8'hFF
                                                                      : bus.err_cnt + 8'd1;
                            end
                        end
                    end
                    SCALE: begin
                        if (dec_cnt == DEC_W'(DECIM - 1)) begin
                            dec_cnt       <= '0;
                            bus.angle_out <= scaled_c;
                            bus.ang_valid <= 1'b1;
                        end else begin
                            dec_cnt <= dec_cnt + DEC_W'(1);
                        end
                        // A stray byte here is treated as if seen in HUNT
                        if (bus.rx_done && bus.rx_data == HDR0) begin
                            state <= TYPE;
                            sum   <= HDR0;
                        end else begin
                            state <= HUNT;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_angle_frame_parser.sv
// Scoreboard bench for angle_frame_parser: one default instance and one with DECIM=3
// share the same byte stream.
module tb_angle_frame_parser;
    localparam int unsigned NCH   = 3;
    localparam int unsigned OUT_W = 16;
    localparam int unsigned FL    = 11;
    localparam int unsigned TMO   = 5000;
    localparam int unsigned VW    = NCH * OUT_W;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;

    always #5 clk = ~clk;

    angle_frame_parser_if #(.NCH(NCH), .OUT_W(OUT_W)) bus_a ();
    angle_frame_parser_if #(.NCH(NCH), .OUT_W(OUT_W)) bus_b ();

    assign bus_a.rx_data = rx_data;
    assign bus_a.rx_done = rx_done;
    assign bus_b.rx_data = rx_data;
    assign bus_b.rx_done = rx_done;

    angle_frame_parser dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    angle_frame_parser #(.DECIM(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    int total = 0;
    int bad   = 0;
    logic [VW-1:0] q_a[$];
    logic [VW-1:0] q_b[$];
    logic [VW-1:0] last_a = '0;
    int good_cnt = 0;
    int exp_err  = 0;
    int pulses_b = 0;
    logic [7:0] fr [FL];

    // Reference scaling: |raw|*41/4096 truncated, sign restored
    function automatic logic [OUT_W-1:0] model_scale(input logic signed [15:0] raw);
        int v;
        int q;
        v = raw;
        if (v < 0) v = -v;
        q = (v * 41) / 4096;
        if (raw < 0) q = -q;
        return OUT_W'(q);
    endfunction

    function automatic logic [VW-1:0] exp_vec(input logic [15:0] w0, input logic [15:0] w1,
                                              input logic [15:0] w2);
        return {model_scale(w2), model_scale(w1), model_scale(w0)};
    endfunction

    task automatic make_frame(input logic [15:0] w0, input logic [15:0] w1,
                              input logic [15:0] w2);
        logic [7:0] s;
        fr[0] = 8'h55; fr[1] = 8'h53;
        fr[2] = w0[7:0]; fr[3] = w0[15:8];
        fr[4] = w1[7:0]; fr[5] = w1[15:8];
        fr[6] = w2[7:0]; fr[7] = w2[15:8];
        fr[8] = 8'h00;   fr[9] = 8'h00;
        s = 8'h00;
        for (int i = 0; i < FL - 1; i++) s = s + fr[i];
        fr[FL-1] = s;
    endtask

    // Build a good frame and record what each instance must publish for it
    task automatic prep_good(input logic [15:0] w0, input logic [15:0] w1,
                             input logic [15:0] w2);
        make_frame(w0, w1, w2);
        q_a.push_back(exp_vec(w0, w1, w2));
        good_cnt++;
        if (good_cnt % 3 == 0) q_b.push_back(exp_vec(w0, w1, w2));
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic send_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) send_byte(fr[i]);
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    // Scoreboard: every publish is popped and compared
    always @(negedge clk) begin
        if (bus_a.ang_valid) begin
            total++;
            if (q_a.size() == 0) begin
                bad++;
                $display("FAIL sb_a: unexpected ang_valid angle_out=%h", bus_a.angle_out);
            end else begin
                last_a = q_a.pop_front();
                if (bus_a.angle_out !== last_a) begin
                    bad++;
                    $display("FAIL sb_a: angle_out=%h expected=%h", bus_a.angle_out, last_a);
                end
            end
        end
        if (bus_b.ang_valid) begin
            pulses_b++;
            total++;
            if (q_b.size() == 0) begin
                bad++;
                $display("FAIL sb_b: unexpected ang_valid angle_out=%h", bus_b.angle_out);
            end else begin
                logic [VW-1:0] e;
                e = q_b.pop_front();
                if (bus_b.angle_out !== e) begin
                    bad++;
                    $display("FAIL sb_b: angle_out=%h expected=%h", bus_b.angle_out, e);
                end
            end
        end
    end

    task automatic do_reset();
        rx_done = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        q_a.delete();
        q_b.delete();
        last_a = '0;
        good_cnt = 0;
        exp_err = 0;
        pulses_b = 0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        total += 10;
        if (bus_a.angle_out !== '0) begin bad++; $display("FAIL rst_a_angle: got=%h exp=0", bus_a.angle_out); end
        if (bus_a.ang_valid !== 1'b0) begin bad++; $display("FAIL rst_a_valid: got=%b exp=0", bus_a.ang_valid); end
        if (bus_a.sum_err !== 1'b0) begin bad++; $display("FAIL rst_a_sumerr: got=%b exp=0", bus_a.sum_err); end
        if (bus_a.tmo_err !== 1'b0) begin bad++; $display("FAIL rst_a_tmoerr: got=%b exp=0", bus_a.tmo_err); end
        if (bus_a.err_cnt !== 8'd0) begin bad++; $display("FAIL rst_a_errcnt: got=%0d exp=0", bus_a.err_cnt); end
        if (bus_b.angle_out !== '0) begin bad++; $display("FAIL rst_b_angle: got=%h exp=0", bus_b.angle_out); end
        if (bus_b.ang_valid !== 1'b0) begin bad++; $display("FAIL rst_b_valid: got=%b exp=0", bus_b.ang_valid); end
        if (bus_b.sum_err !== 1'b0) begin bad++; $display("FAIL rst_b_sumerr: got=%b exp=0", bus_b.sum_err); end
        if (bus_b.tmo_err !== 1'b0) begin bad++; $display("FAIL rst_b_tmoerr: got=%b exp=0", bus_b.tmo_err); end
        if (bus_b.err_cnt !== 8'd0) begin bad++; $display("FAIL rst_b_errcnt: got=%0d exp=0", bus_b.err_cnt); end
    endtask

    // 55 53 28 23 6C EE 00 00 00 00 4D -> +90, -45, 0 at T+2
    task automatic test_good_frame();
        prep_good(16'h2328, 16'hEE6C, 16'h0000);
        send_range(0, FL - 1);
        total += 3;
        if (bus_a.ang_valid !== 1'b0) begin bad++; $display("FAIL lat_t1_valid: got=%b exp=0", bus_a.ang_valid); end
        if (bus_a.sum_err !== 1'b0) begin bad++; $display("FAIL good_sumerr: got=%b exp=0", bus_a.sum_err); end
        @(negedge clk);
        if (bus_a.ang_valid !== 1'b1) begin bad++; $display("FAIL lat_t2_valid: got=%b exp=1", bus_a.ang_valid); end
        total++;
        if (bus_a.angle_out !== {16'd0, 16'hFFD3, 16'd90}) begin
            bad++;
            $display("FAIL good_angle: got=%h exp=%h", bus_a.angle_out, {16'd0, 16'hFFD3, 16'd90});
        end
        settle();
    endtask

    task automatic test_bad_checksum();
        make_frame(16'h2328, 16'hEE6C, 16'h0000);
        fr[FL-1] = 8'h4E;
        send_range(0, FL - 1);
        exp_err++;
        total++;
        if (bus_a.sum_err !== 1'b1) begin bad++; $display("FAIL sumerr_pulse: got=%b exp=1", bus_a.sum_err); end
        @(negedge clk);
        total += 4;
        if (bus_a.sum_err !== 1'b0) begin bad++; $display("FAIL sumerr_width: got=%b exp=0", bus_a.sum_err); end
        if (bus_a.ang_valid !== 1'b0) begin bad++; $display("FAIL bad_valid: got=%b exp=0", bus_a.ang_valid); end
        if (bus_a.err_cnt !== 8'(exp_err)) begin bad++; $display("FAIL bad_errcnt: got=%0d exp=%0d", bus_a.err_cnt, exp_err); end
        if (bus_a.angle_out !== last_a) begin bad++; $display("FAIL bad_hold: got=%h exp=%h", bus_a.angle_out, last_a); end
        prep_good(16'd1000, 16'hFFFF, 16'h7FFF);
        send_range(0, FL - 1);
        settle();
    endtask

    // Noise, then 55 55 53: second 55 resyncs in TYPE
    task automatic test_resync();
        prep_good(16'h8000, 16'd100, 16'hFF9C);
        send_byte(8'h00);
        send_byte(8'hAA);
        send_byte(8'h53);
        send_byte(8'h55);
        send_range(0, FL - 1);
        settle();
        total++;
        if (bus_a.angle_out[15:0] !== 16'hFEB8) begin
            bad++;
            $display("FAIL min_raw: got=%h exp=feb8", bus_a.angle_out[15:0]);
        end
    endtask

    task automatic test_extremes();
        prep_good(16'h7FFF, 16'h8001, 16'd12345);
        send_range(0, FL - 1);
        settle();
        total++;
        if (bus_a.angle_out[15:0] !== 16'd327) begin
            bad++;
            $display("FAIL max_raw: got=%0d exp=327", bus_a.angle_out[15:0]);
        end
    endtask

    task automatic test_timeout();
        int k;
        bit seen;
        bit fired;
        make_frame(16'd500, 16'd0, 16'd0);
        send_range(0, 4);
        seen = 1'b0;
        k = 0;
        while (!seen && k < 2 * TMO) begin
            @(negedge clk);
            k++;
            if (bus_a.tmo_err) seen = 1'b1;
        end
        exp_err++;
        total++;
        if (!seen || k != TMO) begin
            bad++;
            $display("FAIL tmo_delay: seen=%0b after=%0d exp=%0d", seen, k, TMO);
        end
        @(negedge clk);
        total += 2;
        if (bus_a.tmo_err !== 1'b0) begin bad++; $display("FAIL tmo_width: got=%b exp=0", bus_a.tmo_err); end
        if (bus_a.err_cnt !== 8'(exp_err)) begin bad++; $display("FAIL tmo_errcnt: got=%0d exp=%0d", bus_a.err_cnt, exp_err); end

        // Byte landing on the expiry edge keeps the frame alive
        prep_good(16'd500, 16'hFE0C, 16'd4096);
        send_range(0, 4);
        fired = 1'b0;
        repeat (TMO - 2) begin
            @(negedge clk);
            if (bus_a.tmo_err) fired = 1'b1;
        end
        send_byte(fr[5]);
        if (bus_a.tmo_err) fired = 1'b1;
        send_range(6, FL - 1);
        settle();
        total += 2;
        if (fired) begin bad++; $display("FAIL tmo_race: tmo_err=1 exp=0"); end
        if (bus_a.err_cnt !== 8'(exp_err)) begin bad++; $display("FAIL tmo_race_errcnt: got=%0d exp=%0d", bus_a.err_cnt, exp_err); end
    endtask

    task automatic test_err_saturate();
        make_frame(16'd0, 16'd0, 16'd0);
        fr[FL-1] = fr[FL-1] + 8'd1;
        for (int n = 0; n < 260; n++) begin
            send_range(0, FL - 1);
            if (exp_err < 255) exp_err++;
        end
        settle();
        total++;
        if (bus_a.err_cnt !== 8'(exp_err)) begin bad++; $display("FAIL err_sat: got=%0d exp=%0d", bus_a.err_cnt, exp_err); end
    endtask

    task automatic test_decim();
        do_reset();
        for (int f = 1; f <= 5; f++) begin
            prep_good(16'(f * 1000), 16'(-(f * 777)), 16'(f * 3));
            send_range(0, FL - 1);
            settle();
        end
        total += 2;
        if (pulses_b != 1) begin bad++; $display("FAIL decim_pulses: got=%0d exp=1", pulses_b); end
        if (bus_b.angle_out !== exp_vec(16'd3000, 16'(-2331), 16'd9)) begin
            bad++;
            $display("FAIL decim_angle: got=%h exp=%h", bus_b.angle_out, exp_vec(16'd3000, 16'(-2331), 16'd9));
        end
    endtask

    task automatic test_reset_mid_frame();
        make_frame(16'd1234, 16'd0, 16'd0);
        send_range(0, 3);
        rst_n = 1'b0;
        #1;
        total += 4;
        if (bus_a.angle_out !== '0) begin bad++; $display("FAIL rstmid_angle: got=%h exp=0", bus_a.angle_out); end
        if (bus_a.err_cnt !== 8'd0) begin bad++; $display("FAIL rstmid_errcnt: got=%0d exp=0", bus_a.err_cnt); end
        if (bus_b.angle_out !== '0) begin bad++; $display("FAIL rstmid_b_angle: got=%h exp=0", bus_b.angle_out); end
        if (bus_a.ang_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid: got=%b exp=0", bus_a.ang_valid); end
        q_a.delete();
        q_b.delete();
        good_cnt = 0;
        exp_err = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        prep_good(16'hF000, 16'd2500, 16'hC000);
        send_range(0, FL - 1);
        settle();
        total++;
        if (bus_a.angle_out !== exp_vec(16'hF000, 16'd2500, 16'hC000)) begin
            bad++;
            $display("FAIL rstmid_after: got=%h exp=%h", bus_a.angle_out, exp_vec(16'hF000, 16'd2500, 16'hC000));
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_resync();
        test_extremes();
        test_timeout();
        test_err_saturate();
        test_decim();
        test_reset_mid_frame();
        total += 2;
        if (q_a.size() != 0) begin bad++; $display("FAIL sb_a_drain: pending=%0d exp=0", q_a.size()); end
        if (q_b.size() != 0) begin bad++; $display("FAIL sb_b_drain: pending=%0d exp=0", q_b.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
